// File: rtl/neo_gbus_bridge.sv
// CPU-to-port bus bridge: one CPU cycle request is steered to a single
// selected port with a per-port programmable wait count, a one-cycle
// read/write strobe, a read-data capture and a held acknowledge.
module neo_gbus_bridge #(
    parameter int DW    = 16,
    parameter int NPORT = 2,
    parameter int WW    = 4
) (
    input  logic                CLK,
    input  logic                nRESET,
    input  logic                nCYC,
    input  logic [NPORT-1:0]    nSEL,
    input  logic                DIR,
    input  logic [DW-1:0]       M68K_DOUT,
    output logic [DW-1:0]       M68K_DIN,
    output logic                DIN_OE,
    output logic                nDTACK,
    input  logic [NPORT*WW-1:0] WAIT_CFG,
    output logic [DW-1:0]       PORT_DOUT,
    output logic [NPORT-1:0]    nPORT_WE,
    output logic [NPORT-1:0]    PORT_RE,
    input  logic [NPORT*DW-1:0] PORT_DIN,
    output logic                CONFLICT,
    output logic                BUSY
);

    localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_STROBE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_ACK     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic             r_dir;
    logic             r_abort;
    logic             r_armed;
    logic [DW-1:0]    r_din;
    logic [DW-1:0]    r_dout;
    logic [NPORT-1:0] r_we_n;
    logic [NPORT-1:0] r_re;
    logic             r_dtack_n;
    logic             r_oe;
    logic             r_conflict;

    logic             w_any;
    logic             w_multi;
    logic [IW-1:0]    w_sel_idx;
    logic             w_start;
    logic             w_single;
    logic [WW-1:0]    w_wait_sel;
    logic [IW-1:0]    w_idx_nxt;
    logic             w_dir_nxt;
    logic [NPORT-1:0] w_we_n_nxt;
    logic [NPORT-1:0] w_re_nxt;

    // Decode the active-low selects: any selected, more than one selected, and which one.
    always_comb begin
        w_any     = 1'b0;
        w_multi   = 1'b0;
        w_sel_idx = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (!nSEL[i]) begin
                w_multi   = w_multi | w_any;
                w_any     = 1'b1;
                w_sel_idx = IW'(i);
            end
        end
    end

    // A start needs nCYC to have been seen high since the previous start (or reset).
    assign w_start    = (r_state == S_IDLE) && r_armed && !nCYC && w_any;
    assign w_single   = w_start && !w_multi;
    assign w_wait_sel = WAIT_CFG[w_sel_idx*WW +: WW];
    assign w_idx_nxt  = (r_state == S_IDLE) ? w_sel_idx : r_idx;
    assign w_dir_nxt  = (r_state == S_IDLE) ? DIR : r_dir;

    // Next-state logic for the cycle sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_multi)
                        w_state_nxt = S_ACK;
                    else if (w_wait_sel != '0)
                        w_state_nxt = S_WAIT;
                    else
                        w_state_nxt = S_STROBE;
                end
            end
            S_WAIT: begin
                if (nCYC)
                    w_state_nxt = S_IDLE;
                else if (r_cnt == WW'(1))
                    w_state_nxt = S_STROBE;
            end
            S_STROBE:  w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = (r_abort || nCYC) ? S_DONE : S_ACK;
            S_ACK: begin
                if (nCYC)
                    w_state_nxt = S_IDLE;
            end
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Port strobes are registered from the next state so they are glitch-free.
    always_comb begin
        w_we_n_nxt = '1;
        w_re_nxt   = '0;
        if (w_state_nxt == S_STROBE) begin
            if (w_dir_nxt)
                w_re_nxt[w_idx_nxt] = 1'b1;
            else
                w_we_n_nxt[w_idx_nxt] = 1'b0;
        end
    end

    // State, wait counter, latched request and re-arm tracking.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_dir   <= 1'b0;
            r_abort <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == S_WAIT)
                r_cnt <= (r_state == S_IDLE) ? w_wait_sel : r_cnt - 1'b1;
            else
                r_cnt <= '0;
            if (w_single)
                r_idx <= w_sel_idx;
            if (w_start)
                r_dir <= DIR;
            // Remember a release seen in STROBE so CAPTURE still diverts to DONE.
            if (r_state == S_STROBE)
                r_abort <= nCYC;
            else if (r_state != S_CAPTURE)
                r_abort <= 1'b0;
            if (nCYC)
                r_armed <= 1'b1;
            else if (w_start)
                r_armed <= 1'b0;
        end
    end

    // Data paths: write data latched at start, read data captured leaving CAPTURE.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_din  <= '0;
            r_dout <= '0;
        end else begin
            if (w_single)
                r_dout <= M68K_DOUT;
            if (w_start && w_multi)
                r_din <= '1;
            else if (r_state == S_CAPTURE && r_dir)
                r_din <= PORT_DIN[r_idx*DW +: DW];
        end
    end

    // Registered bus-facing control outputs; conflict flag is sticky until reset.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_we_n     <= '1;
            r_re       <= '0;
            r_dtack_n  <= 1'b1;
            r_oe       <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_we_n    <= w_we_n_nxt;
            r_re      <= w_re_nxt;
            r_dtack_n <= (w_state_nxt != S_ACK);
            r_oe      <= (w_state_nxt == S_ACK) && w_dir_nxt;
            if (w_start && w_multi)
                r_conflict <= 1'b1;
        end
    end

    assign M68K_DIN  = r_din;
    assign PORT_DOUT = r_dout;
    assign nPORT_WE  = r_we_n;
    assign PORT_RE   = r_re;
    assign nDTACK    = r_dtack_n;
    assign DIN_OE    = r_oe;
    assign CONFLICT  = r_conflict;
    assign BUSY      = (r_state != S_IDLE);

endmodule
